hazard_seq_ctrl: RTL and testbench
==================================

HAZARD_SEQ_CTRL -- requirements
Module: hazard_seq_ctrl

Interface
REQ-001 The block SHALL have one clock, `clk`; reset `rst` SHALL be synchronous and active-high.
REQ-002 Parameter `MUL_LAT`, default 4: multiplier latency in cycles; legal range 2..15.
REQ-003 Parameter `CNT_W`, default 32: width of the performance counters.
REQ-004 The ports SHALL be, in order:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rs1_d  in  5  source register 1 of the instruction in ID
- rs2_d  in  5  source register 2 of the instruction in ID
- rd_e  in  5  destination register of the instruction in EX
- mem_read_e  in  1  instruction in EX is a load
- branch_taken_e  in  1  taken branch/jump resolved in EX
- mul_start_e  in  1  one-cycle pulse: a multiply has entered EX
- stall_f  out  1  hold PC
- stall_d  out  1  hold IF/ID
- stall_e  out  1  hold ID/EX
- flush_d  out  1  clear IF/ID
- flush_e  out  1  clear ID/EX (insert bubble)
- mul_busy  out  1  FSM in MUL_WAIT
- stall_cnt  out  CNT_W  stall cycles (present only under REQ-019)
- flush_cnt  out  CNT_W  taken-branch flushes (present only under REQ-019)

Function
REQ-005 The FSM SHALL have exactly two states, RUN and MUL_WAIT, and a 4-bit down-counter `mcnt`.
REQ-006 `lu` SHALL be defined as mem_read_e AND rd_e != 0 AND (rd_e == rs1_d OR rd_e == rs2_d), evaluated combinationally.
REQ-007 In RUN with branch_taken_e=1, the same cycle SHALL assert flush_d=1 and flush_e=1, with all stalls at 0; the FSM SHALL stay in RUN.
REQ-008 In RUN with branch_taken_e=0 and mul_start_e=1, the block SHALL assert stall_f, stall_d, stall_e and mul_busy combinationally that cycle, load mcnt with MUL_LAT-2, and go to MUL_WAIT.
REQ-009 In RUN with branch_taken_e=0, mul_start_e=0 and lu=1, the block SHALL assert stall_f=1, stall_d=1, flush_e=1 and stall_e=0 for exactly that cycle (one bubble), staying in RUN.
REQ-010 Priority in RUN SHALL be branch_taken_e > mul_start_e > lu.
REQ-011 In MUL_WAIT, stall_f, stall_d, stall_e and mul_busy SHALL be 1 and flush_d and flush_e SHALL be 0.
- branch_taken_e, mul_start_e and lu are ignored.
REQ-012 In MUL_WAIT, mcnt SHALL decrement each cycle; when mcnt==0 the next state SHALL be RUN.
- Total stall cycles per multiply = MUL_LAT-1.
REQ-013 In the first RUN cycle after MUL_WAIT, all inputs SHALL be evaluated normally per REQ-007..010.
REQ-014 In RUN with no event, all control outputs SHALL be 0.
REQ-015 Every output except the counters SHALL be combinational from state and inputs, with no additional latency.

Reset
REQ-016 While rst=1 the block SHALL force state=RUN and mcnt=0, and all of stall_*, flush_* and mul_busy SHALL read 0 regardless of inputs.
REQ-017 rst asserted during MUL_WAIT SHALL abort the sequence; the first cycle after rst deasserts SHALL be RUN.
REQ-018 Counters, when present, SHALL reset to 0.

Configuration
REQ-019 With macro `HAZARD_PERF_CNT_EN` defined, the block SHALL implement the counters as follows:
- stall_cnt increments by 1 in every cycle with stall_f=1.
- flush_cnt increments by 1 in every cycle with flush_d=1.
- Both wrap modulo 2^CNT_W.
REQ-020 With `HAZARD_PERF_CNT_EN` undefined, the ports stall_cnt and flush_cnt and their registers SHALL NOT exist; all other behaviour SHALL be identical.

Verification
REQ-021 Load-use: mem_read_e=1, rd_e=5, rs1_d=5 in RUN -> stall_f=stall_d=flush_e=1 and stall_e=0 for 1 cycle.
- rd_e=0 with rs1_d=0 -> no stall.
REQ-022 Multiply with MUL_LAT=4: pulse mul_start_e -> stall_f, stall_d and stall_e high for exactly 3 cycles, mul_busy high for the same 3 cycles, then all 0.
REQ-023 Simultaneous events: branch_taken_e=1, mul_start_e=1 and lu=1 in RUN -> flush_d=flush_e=1, no stall, state stays RUN.
- branch_taken_e=1 during MUL_WAIT -> ignored, no flush.
REQ-024 Reset mid-operation: rst=1 on the 2nd MUL_WAIT cycle -> outputs 0 that cycle; RUN afterwards; a new mul_start_e gives a full MUL_LAT-1 stall.
REQ-025 With HAZARD_PERF_CNT_EN and CNT_W=4: 15 stall cycles, then 1 more -> stall_cnt wraps 15->0.
- 3 taken branches -> flush_cnt=3.

Source files
------------

// File: rtl/hazard_seq_ctrl.sv
// hazard_seq_ctrl: pipeline hazard sequencer for a 5-stage core.
// Resolves taken-branch flushes, load-use bubbles and multi-cycle multiply
// stalls from the instructions currently in ID and EX.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   rs1_d, rs2_d     source registers of the instruction in ID
//   rd_e             destination register of the instruction in EX
//   mem_read_e       instruction in EX is a load
//   branch_taken_e   taken branch/jump resolved in EX
//   mul_start_e      one-cycle pulse: multiply entered EX
//   stall_f/d/e      hold PC, IF/ID, ID/EX
//   flush_d/e        clear IF/ID, clear ID/EX (bubble)
//   mul_busy         multiply wait sequence in progress
//   stall_cnt        stall cycle counter     (HAZARD_PERF_CNT_EN only)
//   flush_cnt        branch flush counter    (HAZARD_PERF_CNT_EN only)
//
// Parameters: MUL_LAT (2..15) multiplier latency, CNT_W counter width.
// Optional feature: define HAZARD_PERF_CNT_EN to build the perf counters.
// All control outputs are combinational from state and inputs.

module hazard_seq_ctrl #(
    parameter int unsigned MUL_LAT = 4,
    parameter int unsigned CNT_W   = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] rs1_d,
    input  logic [4:0] rs2_d,
    input  logic [4:0] rd_e,
    input  logic       mem_read_e,
    input  logic       branch_taken_e,
    input  logic       mul_start_e,
    output logic       stall_f,
    output logic       stall_d,
    output logic       stall_e,
    output logic       flush_d,
    output logic       flush_e,
    output logic       mul_busy
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    localparam int unsigned MCNT_W = 4;
    // The start cycle is itself one stall cycle, so MUL_WAIT lasts MUL_LAT-2.
    localparam logic [MCNT_W-1:0] MCNT_LOAD = MCNT_W'(MUL_LAT - 2);

    typedef enum logic {
        RUN      = 1'b0,
        MUL_WAIT = 1'b1
    } state_t;

    state_t            state, state_nxt;
    logic [MCNT_W-1:0] mcnt, mcnt_nxt;
    logic              lu;

    // Load-use hazard: a load in EX writes a register read by ID.
    assign lu = mem_read_e && (rd_e != 5'd0) && ((rd_e == rs1_d) || (rd_e == rs2_d));

    // State and wait counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            mcnt  <= '0;
        end else begin
            state <= state_nxt;
            mcnt  <= mcnt_nxt;
        end
    end

    // Next state and control outputs.
    always_comb begin
        state_nxt = state;
        mcnt_nxt  = mcnt;
        stall_f   = 1'b0;
        stall_d   = 1'b0;
        stall_e   = 1'b0;
        flush_d   = 1'b0;
        flush_e   = 1'b0;
        mul_busy  = 1'b0;

        case (state)
            RUN: begin
                if (branch_taken_e) begin
                    flush_d = 1'b1;
                    flush_e = 1'b1;
                end else if (mul_start_e) begin
                    stall_f  = 1'b1;
                    stall_d  = 1'b1;
                    stall_e  = 1'b1;
                    mul_busy = 1'b1;
                    mcnt_nxt = MCNT_LOAD;
                    // With MUL_LAT=2 the start cycle alone covers the latency.
                    state_nxt = (MCNT_LOAD == '0) ? RUN : MUL_WAIT;
                end else if (lu) begin
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    flush_e = 1'b1;
                end
            end
            MUL_WAIT: begin
                stall_f  = 1'b1;
                stall_d  = 1'b1;
                stall_e  = 1'b1;
                mul_busy = 1'b1;
                // mcnt counts the MUL_WAIT cycles left including this one;
                // it reaches 0 on the way back to RUN.
                mcnt_nxt = mcnt - MCNT_W'(1);
                if (mcnt <= MCNT_W'(1)) begin
                    mcnt_nxt  = '0;
                    state_nxt = RUN;
                end
            end
            default: begin
                state_nxt = RUN;
                mcnt_nxt  = '0;
            end
        endcase

        // Reset masks every control output regardless of inputs.
        if (rst) begin
            stall_f  = 1'b0;
            stall_d  = 1'b0;
            stall_e  = 1'b0;
            flush_d  = 1'b0;
            flush_e  = 1'b0;
            mul_busy = 1'b0;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    // Performance counters, wrapping modulo 2^CNT_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            stall_cnt <= stall_cnt + CNT_W'(stall_f);
            flush_cnt <= flush_cnt + CNT_W'(flush_d);
        end
    end
`else
    // Counters not built.
`endif

endmodule

// File: tb/tb_hazard_seq_ctrl.sv
// Scoreboard bench for hazard_seq_ctrl (MUL_LAT=4, CNT_W=4).
// The driver applies one vector per cycle and queues its expected controls;
// the monitor pops and compares on the falling edge.

module tb_hazard_seq_ctrl;

    localparam int unsigned MUL_LAT = 4;
    localparam int unsigned CNT_W   = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] rs1_d = '0, rs2_d = '0, rd_e = '0;
    logic       mem_read_e = 1'b0, branch_taken_e = 1'b0, mul_start_e = 1'b0;
    logic       stall_f, stall_d, stall_e, flush_d, flush_e, mul_busy;
`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
`endif

    hazard_seq_ctrl #(.MUL_LAT(MUL_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_e(rd_e),
        .mem_read_e(mem_read_e), .branch_taken_e(branch_taken_e),
        .mul_start_e(mul_start_e),
        .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e),
        .flush_d(flush_d), .flush_e(flush_e), .mul_busy(mul_busy)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    // ctl = {stall_f, stall_d, stall_e, flush_d, flush_e, mul_busy}
    typedef struct {
        string      name;
        logic [5:0] ctl;
        logic       chk_cnt;
        logic [3:0] sc;
        logic [3:0] fc;
    } exp_t;

    localparam logic [5:0] NONE = 6'b000000;
    localparam logic [5:0] LU   = 6'b110010;
    localparam logic [5:0] BR   = 6'b000110;
    localparam logic [5:0] MUL  = 6'b111001;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic drive(input string nm, input logic r, input logic [4:0] a,
                         input logic [4:0] b, input logic [4:0] d, input logic mr,
                         input logic br, input logic ms, input logic [5:0] e,
                         input logic cc = 1'b0, input logic [3:0] sc = 4'd0,
                         input logic [3:0] fc = 4'd0);
        exp_t x;
        @(posedge clk);
        #1;
        rst = r; rs1_d = a; rs2_d = b; rd_e = d;
        mem_read_e = mr; branch_taken_e = br; mul_start_e = ms;
        x.name = nm; x.ctl = e; x.chk_cnt = cc; x.sc = sc; x.fc = fc;
        exp_q.push_back(x);
    endtask

    task automatic idle(input string nm, input logic [5:0] e = NONE);
        drive(nm, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, e);
    endtask

    // Monitor: compare queued expectation against the settled outputs.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t x;
            logic [5:0] act;
            x   = exp_q.pop_front();
            act = {stall_f, stall_d, stall_e, flush_d, flush_e, mul_busy};
            checks++;
            if (act !== x.ctl) begin
                errors++;
                $display("FAIL %s: ctl got %b expected %b", x.name, act, x.ctl);
            end
`ifdef HAZARD_PERF_CNT_EN
            if (x.chk_cnt) begin
                checks++;
                if (stall_cnt !== x.sc || flush_cnt !== x.fc) begin
                    errors++;
                    $display("FAIL %s: cnt got stall=%0d flush=%0d expected stall=%0d flush=%0d",
                             x.name, stall_cnt, flush_cnt, x.sc, x.fc);
                end
            end
`endif
        end
    end

    initial begin
        // Reset masks outputs even with active inputs.
        drive("rst_br",  1'b1, 5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, NONE);
        drive("rst_mul", 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, NONE);
        idle("idle0");

        // Load-use via rs1 and rs2, and the non-hazard cases.
        drive("lu_rs1",  1'b0, 5'd5, 5'd9, 5'd5, 1'b1, 1'b0, 1'b0, LU);
        idle("lu_rs1_after");
        drive("lu_rs2",  1'b0, 5'd1, 5'd7, 5'd7, 1'b1, 1'b0, 1'b0, LU);
        drive("lu_x0",   1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, NONE);
        drive("no_load", 1'b0, 5'd5, 5'd5, 5'd5, 1'b0, 1'b0, 1'b0, NONE);
        drive("lu_nomatch", 1'b0, 5'd3, 5'd4, 5'd6, 1'b1, 1'b0, 1'b0, NONE);

        // Taken branch.
        drive("branch", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, BR);
        idle("branch_after");

        // Multiply: 3 stall cycles; branch and load-use ignored while waiting.
        drive("mul_start", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, MUL);
        drive("mul_w1_br", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, MUL);
        drive("mul_w2_lu", 1'b0, 5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b1, MUL);
        idle("mul_done");

        // All three events at once: branch wins, stays in RUN.
        drive("simul", 1'b0, 5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b1, BR);
        idle("simul_after");

        // First RUN cycle after a multiply evaluates inputs normally.
        drive("mul2_start", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, MUL);
        idle("mul2_w1", MUL);
        idle("mul2_w2", MUL);
        drive("post_mul_lu", 1'b0, 5'd8, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0, LU);
        drive("back2back_mul", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, MUL);
        idle("b2b_w1", MUL);
        idle("b2b_w2", MUL);
        drive("post_mul_br", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, BR);

        // Reset on the 2nd MUL_WAIT cycle aborts; new multiply is full length.
        drive("abort_start", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, MUL);
        idle("abort_w1", MUL);
        drive("abort_rst", 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, NONE);
        idle("abort_run");
        drive("re_start", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, MUL);
        idle("re_w1", MUL);
        idle("re_w2", MUL);
        idle("re_done");

`ifdef HAZARD_PERF_CNT_EN
        // Counters: 3 flushes, then 15 stalls plus one to wrap.
        drive("cnt_rst", 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, NONE);
        drive("cnt_zero", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, NONE,
              1'b1, 4'd0, 4'd0);
        for (int i = 0; i < 3; i++)
            drive("cnt_br", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, BR,
                  1'b1, 4'd0, 4'(i));
        drive("cnt_flush3", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, NONE,
              1'b1, 4'd0, 4'd3);
        for (int i = 0; i < 15; i++)
            drive("cnt_lu", 1'b0, 5'd2, 5'd0, 5'd2, 1'b1, 1'b0, 1'b0, LU,
                  1'b1, 4'(i), 4'd3);
        drive("cnt_stall15", 1'b0, 5'd2, 5'd0, 5'd2, 1'b1, 1'b0, 1'b0, LU,
              1'b1, 4'd15, 4'd3);
        drive("cnt_wrap", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, NONE,
              1'b1, 4'd0, 4'd3);
`endif

        // Drain the scoreboard with a bounded wait.
        begin
            int budget;
            budget = 0;
            while (exp_q.size() > 0 && budget < 20) begin
                @(posedge clk);
                budget++;
            end
            if (exp_q.size() > 0) begin
                errors++;
                $display("FAIL drain: %0d entries left expected 0", exp_q.size());
            end
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
